prog_sequencer: RTL and testbench

Multi-cycle run controller for the 9-bit accumulator core. It owns the program counter and sequences each instruction through fetch, execute and an optional data-memory wait. It gates register and memory writes so each instruction commits exactly once, and it implements the Start/Done handshake with the test harness. It sits between the instruction decoder (Jump, BranchEn, LoadInst, MemWrEn, Ack), the branch LUT, the data memory and the instruction ROM.

---
 rtl/prog_sequencer_pkg.sv | 17 +
 rtl/prog_sequencer_if.sv | 38 +++
 rtl/prog_sequencer_next_pc_logic.sv | 49 ++++
 rtl/prog_sequencer.sv | 124 ++++++++++++
 tb/tb_prog_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: state encoding, default
// program-counter width and the performance-counter ceiling.
package prog_sequencer_pkg;

  localparam int PC_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    MEM_WAIT = 3'd3,
    HALT     = 3'd4
  } seq_state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/prog_sequencer_if.sv
// Handshake/decoder bundle between the harness, decoder, branch LUT, data
// memory and the sequencer. The master side drives decoder flags and the
// handshake inputs; the slave side is the sequencer.
interface prog_sequencer_if
  import prog_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
);

  logic            Start;
  logic            Jump;
  logic            BranchEn;
  logic            Taken;
  logic            LoadInst;
  logic            MemWrEn;
  logic            Ack;
  logic [PC_W-1:0] LutTarget;
  logic [PC_W-1:0] RegTarget;
  logic            MemReady;
  logic [PC_W-1:0] ProgCtr;
  logic            CommitEn;
  logic            MemReq;
  logic            Done;
  logic [2:0]      SeqState;

  modport master (
    output Start, Jump, BranchEn, Taken, LoadInst, MemWrEn, Ack,
    output LutTarget, RegTarget, MemReady,
    input  ProgCtr, CommitEn, MemReq, Done, SeqState
  );

  modport slave (
    input  Start, Jump, BranchEn, Taken, LoadInst, MemWrEn, Ack,
    input  LutTarget, RegTarget, MemReady,
    output ProgCtr, CommitEn, MemReq, Done, SeqState
  );

endinterface

// File: rtl/prog_sequencer_next_pc_logic.sv
// Next program-counter mux: hold, ProgCtr+1 (wrapping), LUT target,
// register target, or zero on Start, chosen by the current state and the
// decoder flags.
module next_pc_logic
  import prog_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  seq_state_t      state,
  input  logic            start,
  input  logic            jump,
  input  logic            branch_en,
  input  logic            taken,
  input  logic            load_inst,
  input  logic            mem_wr_en,
  input  logic            ack,
  input  logic            mem_ready,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] lut_target,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] pc_next
);

  // Select the program counter for the next cycle; hold unless an instruction retires.
  always_comb begin
    // NOTE: assign the default first so every path drives pc_next and no latch is inferred.
    pc_next = pc;
    if (start) begin
      pc_next = '0;
    end else begin
      case (state)
        EXEC: begin
          if (ack || load_inst || mem_wr_en) begin
            pc_next = pc;
          end else if (branch_en && taken) begin
            pc_next = jump ? lut_target : reg_target;
          end else begin
            pc_next = pc + 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) pc_next = pc + 1'b1;
        end
        default: pc_next = pc;
      endcase
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Multi-cycle run controller: owns the program counter, steps each
// instruction through FETCH/EXEC/MEM_WAIT, gates commits to one per
// instruction and handles the Start/Done handshake.
// Optional build macro SEQ_PERF_EN adds CycleCnt/InstrCnt counters.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  prog_sequencer_if.slave       bus
`ifdef SEQ_PERF_EN
  ,
  output logic [31:0]           CycleCnt,
  output logic [31:0]           InstrCnt
`endif
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            commit_en;

  next_pc_logic #(.PC_W(PC_W)) u_next_pc (
    .state      (state_q),
    .start      (bus.Start),
    .jump       (bus.Jump),
    .branch_en  (bus.BranchEn),
    .taken      (bus.Taken),
    .load_inst  (bus.LoadInst),
    .mem_wr_en  (bus.MemWrEn),
    .ack        (bus.Ack),
    .mem_ready  (bus.MemReady),
    .pc         (pc_q),
    .lut_target (bus.LutTarget),
    .reg_target (bus.RegTarget),
    .pc_next    (pc_d)
  );

  // Next-state and commit decode; Start overrides everything and never commits.
  always_comb begin
    state_d   = state_q;
    commit_en = 1'b0;
    if (bus.Start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: state_d = EXEC;
        EXEC: begin
          if (bus.Ack) begin
            state_d = HALT;
          end else if (bus.LoadInst || bus.MemWrEn) begin
            state_d = MEM_WAIT;
          end else begin
            commit_en = 1'b1;
            state_d   = FETCH;
          end
        end
        MEM_WAIT: begin
          if (bus.MemReady) begin
            commit_en = 1'b1;
            state_d   = FETCH;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and program-counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.ProgCtr  = pc_q;
  assign bus.CommitEn = commit_en;
  assign bus.MemReq   = (state_q == MEM_WAIT);
  assign bus.Done     = (state_q == HALT);
  assign bus.SeqState = state_q;

`ifdef SEQ_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  // Saturating counters of active cycles and retired instructions; cleared by Start.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (bus.Start) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end else begin
      if (state_q != IDLE && state_q != HALT && cycle_cnt_q != CNT_MAX)
        cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (commit_en && instr_cnt_q != CNT_MAX)
        instr_cnt_d = instr_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign CycleCnt = cycle_cnt_q;
  assign InstrCnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed test-plan scenarios with literal
// expectations, then randomized decoder/handshake traffic, all compared
// every cycle against an instruction-level reference model.
module tb_prog_sequencer;
  import prog_sequencer_pkg::*;

  localparam int PC_W  = 10;
  localparam int PC_MOD = 1 << PC_W;

  logic Clk;
  logic Reset;
  int   n_vec;
  int   n_err;

  prog_sequencer_if #(.PC_W(PC_W)) bus ();

`ifdef SEQ_PERF_EN
  logic [31:0] CycleCnt;
  logic [31:0] InstrCnt;
`endif

  prog_sequencer #(.PC_W(PC_W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus)
`ifdef SEQ_PERF_EN
    ,
    .CycleCnt (CycleCnt),
    .InstrCnt (InstrCnt)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the current instruction and its program counter.
  seq_state_t m_state = IDLE;
  int         m_pc    = 0;

  // Compare DUT against the model mid-cycle, then advance the model by one cycle.
  always @(negedge Clk) begin
    bit is_mem, exp_commit;
    if (Reset) begin
      check("rst_pc", 32'(bus.ProgCtr), 0);
      check("rst_commit", 32'(bus.CommitEn), 0);
      check("rst_memreq", 32'(bus.MemReq), 0);
      check("rst_done", 32'(bus.Done), 0);
      check("rst_state", 32'(bus.SeqState), 32'(IDLE));
      m_state = IDLE;
      m_pc    = 0;
    end else begin
      is_mem     = bus.LoadInst || bus.MemWrEn;
      exp_commit = !bus.Start &&
                   ((m_state == EXEC && !bus.Ack && !is_mem) ||
                    (m_state == MEM_WAIT && bus.MemReady));
      check("pc", 32'(bus.ProgCtr), 32'(m_pc));
      check("state", 32'(bus.SeqState), 32'(m_state));
      check("commit", 32'(bus.CommitEn), 32'(exp_commit));
      check("memreq", 32'(bus.MemReq), 32'(m_state == MEM_WAIT));
      check("done", 32'(bus.Done), 32'(m_state == HALT));
      if (bus.Start) begin
        m_state = IDLE;
        m_pc    = 0;
      end else begin
        case (m_state)
          IDLE:  m_state = FETCH;
          FETCH: m_state = EXEC;
          EXEC: begin
            if (bus.Ack) m_state = HALT;
            else if (is_mem) m_state = MEM_WAIT;
            else begin
              if (bus.BranchEn && bus.Taken)
                m_pc = bus.Jump ? int'(bus.LutTarget) : int'(bus.RegTarget);
              else
                m_pc = (m_pc + 1) % PC_MOD;
              m_state = FETCH;
            end
          end
          MEM_WAIT: begin
            if (bus.MemReady) begin
              m_pc    = (m_pc + 1) % PC_MOD;
              m_state = FETCH;
            end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    bus.Jump      = 1'b0;
    bus.BranchEn  = 1'b0;
    bus.Taken     = 1'b0;
    bus.LoadInst  = 1'b0;
    bus.MemWrEn   = 1'b0;
    bus.Ack       = 1'b0;
    bus.LutTarget = '0;
    bus.RegTarget = '0;
    bus.MemReady  = 1'b0;
  endtask

  // From FETCH: run one taken register-branch to move the PC to a chosen address.
  task automatic goto_pc(input logic [PC_W-1:0] tgt);
    cyc();                       // now EXEC
    bus.BranchEn = 1'b1; bus.Taken = 1'b1; bus.Jump = 1'b0; bus.RegTarget = tgt;
    cyc();                       // now FETCH at tgt
    clr();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    bus.Start = 1'b1;
    clr();

    // Reset/Start sequence
    cyc(); cyc(); #3;
    check("lit_rst_pc", 32'(bus.ProgCtr), 0);
    check("lit_rst_done", 32'(bus.Done), 0);
    Reset = 1'b0;
    cyc(); cyc(); cyc(); #3;
    check("lit_start_idle", 32'(bus.SeqState), 32'(IDLE));
    check("lit_start_pc", 32'(bus.ProgCtr), 0);
    bus.Start = 1'b0;
    cyc(); #3;
    check("lit_first_fetch", 32'(bus.SeqState), 32'(FETCH));
    cyc();                       // EXEC, ALU instruction
    cyc(); #3;
    check("lit_pc_after_exec", 32'(bus.ProgCtr), 1);

    // Taken LUT branch at PC=5
    goto_pc(10'd5);
    cyc();
    bus.BranchEn = 1'b1; bus.Jump = 1'b1; bus.Taken = 1'b1; bus.LutTarget = 10'h3A0;
    #3;
    check("lit_br_commit", 32'(bus.CommitEn), 1);
    cyc(); clr(); #3;
    check("lit_br_taken_pc", 32'(bus.ProgCtr), 32'h3A0);
    check("lit_br_fetch", 32'(bus.SeqState), 32'(FETCH));

    // Not-taken variant
    goto_pc(10'd5);
    cyc();
    bus.BranchEn = 1'b1; bus.Jump = 1'b1; bus.Taken = 1'b0; bus.LutTarget = 10'h3A0;
    cyc(); clr(); #3;
    check("lit_br_not_taken_pc", 32'(bus.ProgCtr), 6);

    // Load at PC=7 with two stall cycles
    cyc(); cyc();                // EXEC at 6 (ALU), then FETCH at 7
    cyc();
    bus.LoadInst = 1'b1;
    #3;
    check("lit_ld_exec_commit", 32'(bus.CommitEn), 0);
    cyc(); clr(); #3;
    check("lit_ld_w1_req", 32'(bus.MemReq), 1);
    check("lit_ld_w1_commit", 32'(bus.CommitEn), 0);
    cyc(); #3;
    check("lit_ld_w2_req", 32'(bus.MemReq), 1);
    check("lit_ld_w2_commit", 32'(bus.CommitEn), 0);
    cyc(); bus.MemReady = 1'b1; #3;
    check("lit_ld_w3_req", 32'(bus.MemReq), 1);
    check("lit_ld_w3_commit", 32'(bus.CommitEn), 1);
    cyc(); clr(); #3;
    check("lit_ld_pc", 32'(bus.ProgCtr), 8);
    check("lit_ld_req_off", 32'(bus.MemReq), 0);

    // Wrap-around
    goto_pc(10'h3FF);
    cyc(); cyc(); #3;
    check("lit_wrap_pc", 32'(bus.ProgCtr), 0);

    // Halt at PC=20
    goto_pc(10'd20);
    cyc(); bus.Ack = 1'b1; #3;
    check("lit_halt_commit", 32'(bus.CommitEn), 0);
    cyc(); clr(); #3;
    check("lit_halt_done", 32'(bus.Done), 1);
    check("lit_halt_pc", 32'(bus.ProgCtr), 20);
    cyc(); #3;
    check("lit_halt_hold_pc", 32'(bus.ProgCtr), 20);
    bus.Start = 1'b1;
    cyc(); #3;
    check("lit_halt_idle", 32'(bus.SeqState), 32'(IDLE));
    check("lit_halt_pc0", 32'(bus.ProgCtr), 0);

    // Abort mid-store with MemReady high
    bus.Start = 1'b0;
    cyc();                       // FETCH
    cyc(); bus.MemWrEn = 1'b1;   // EXEC store
    cyc(); clr();                // MEM_WAIT
    bus.Start = 1'b1; bus.MemReady = 1'b1; #3;
    check("lit_abort_commit", 32'(bus.CommitEn), 0);
    check("lit_abort_req", 32'(bus.MemReq), 1);
    cyc(); clr(); #3;
    check("lit_abort_req_off", 32'(bus.MemReq), 0);
    check("lit_abort_idle", 32'(bus.SeqState), 32'(IDLE));
    check("lit_abort_pc", 32'(bus.ProgCtr), 0);
`ifdef SEQ_PERF_EN
    check("lit_abort_cyclecnt", CycleCnt, 0);
`endif

    // Randomized traffic
    bus.Start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (Reset) Reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) Reset = 1'b1;
      bus.Start     = ($urandom_range(0, 59) == 0);
      bus.Ack       = ($urandom_range(0, 29) == 0);
      bus.LoadInst  = ($urandom_range(0, 9) == 0);
      bus.MemWrEn   = ($urandom_range(0, 9) == 0);
      bus.BranchEn  = ($urandom_range(0, 3) == 0);
      bus.Taken     = $urandom_range(0, 1) == 1;
      bus.Jump      = $urandom_range(0, 1) == 1;
      bus.LutTarget = PC_W'($urandom);
      bus.RegTarget = PC_W'($urandom);
      bus.MemReady  = ($urandom_range(0, 2) == 0);
    end
    cyc();
    @(posedge Clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
